// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: ID-stage operand info, EX redirect, MEM handshake
// in, stall/flush/freeze controls and tracked destination registers out.
interface hazard_ctrl_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_store_reg;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        id_use_store;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_is_load;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        mem_ack;
    logic        stall_pc;
    logic        stall_ifid;
    logic        bubble_idex;
    logic        flush_ifid;
    logic        freeze;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic [4:0]  mem_rd;
    logic        mem_wait;
    logic [15:0] stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_store_reg,
        output id_use_rs1, id_use_rs2, id_use_store,
        output id_rd, id_reg_write, id_is_load,
        output ex_branch_taken, mem_req, mem_ack,
        input  stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze,
        input  ex_rd, ex_is_load, mem_rd, mem_wait, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_store_reg,
        input  id_use_rs1, id_use_rs2, id_use_store,
        input  id_rd, id_reg_write, id_is_load,
        input  ex_branch_taken, mem_req, mem_ack,
        output stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze,
        output ex_rd, ex_is_load, mem_rd, mem_wait, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: memory freeze > branch flush > load-use stall, plus EX/MEM
// destination tracking, a RUN/WAIT memory FSM and a saturating load-use counter.
module hazard_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hif
);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic        ex_is_load_q, ex_is_load_d;
    logic [4:0]  mem_rd_q, mem_rd_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic hold, lu, id_writes;
    logic stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze;

    always_comb begin
        hold = hif.mem_req & ~hif.mem_ack;
        lu = hif.id_valid & ex_is_load_q & (ex_rd_q != 5'd0) &
             ((hif.id_use_rs1   & (hif.id_rs1       == ex_rd_q)) |
              (hif.id_use_rs2   & (hif.id_rs2       == ex_rd_q)) |
              (hif.id_use_store & (hif.id_store_reg == ex_rd_q)));
        id_writes = hif.id_valid & hif.id_reg_write & (hif.id_rd != 5'd0);
    end

    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        freeze      = 1'b0;
        if (hold) begin
            freeze     = 1'b1;
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
        end else if (hif.ex_branch_taken) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
        end else if (lu) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
        end
    end

    always_comb begin
        ex_rd_d       = ex_rd_q;
        ex_is_load_d  = ex_is_load_q;
        mem_rd_d      = mem_rd_q;
        stall_count_d = stall_count_q;
        state_d       = state_q;

        if (!freeze) begin
            mem_rd_d = ex_rd_q;
            if (bubble_idex || !id_writes) begin
                ex_rd_d      = 5'd0;
                ex_is_load_d = 1'b0;
            end else begin
                ex_rd_d      = hif.id_rd;
                ex_is_load_d = hif.id_is_load & hif.id_valid;
            end
        end

        if (lu && !hold && !hif.ex_branch_taken && (stall_count_q != 16'hFFFF))
            stall_count_d = stall_count_q + 16'd1;

        // A dropped request leaves WAIT without an ack (abort).
        case (state_q)
            ST_RUN:  if (hold) state_d = ST_WAIT;
            ST_WAIT: if (hif.mem_ack || !hif.mem_req) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            ex_rd_q       <= '0;
            ex_is_load_q  <= 1'b0;
            mem_rd_q      <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ex_rd_q       <= ex_rd_d;
            ex_is_load_q  <= ex_is_load_d;
            mem_rd_q      <= mem_rd_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign hif.stall_pc    = stall_pc;
    assign hif.stall_ifid  = stall_ifid;
    assign hif.bubble_idex = bubble_idex;
    assign hif.flush_ifid  = flush_ifid;
    assign hif.freeze      = freeze;
    assign hif.ex_rd       = ex_rd_q;
    assign hif.ex_is_load  = ex_is_load_q;
    assign hif.mem_rd      = mem_rd_q;
    assign hif.mem_wait    = (state_q == ST_WAIT);
    assign hif.stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the pipeline rules.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_ctrl_if hif ();

    hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif)
    );

    int errors = 0;
    int checks = 0;

    // behavioural model state
    int m_ex_rd;
    bit m_ex_load;
    int m_mem_rd;
    int m_count;
    bit m_wait;

    // expected {stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze}
    function automatic logic [4:0] exp_ctrl();
        bit hold, lu;
        hold = hif.mem_req && !hif.mem_ack;
        lu = hif.id_valid && m_ex_load && (m_ex_rd != 0) &&
             ((hif.id_use_rs1 && (int'(hif.id_rs1) == m_ex_rd)) ||
              (hif.id_use_rs2 && (int'(hif.id_rs2) == m_ex_rd)) ||
              (hif.id_use_store && (int'(hif.id_store_reg) == m_ex_rd)));
        if (hold) return 5'b11001;
        if (hif.ex_branch_taken) return 5'b00110;
        if (lu) return 5'b11100;
        return 5'b00000;
    endfunction

    function automatic logic [4:0] obs_ctrl();
        return {hif.stall_pc, hif.stall_ifid, hif.bubble_idex, hif.flush_ifid, hif.freeze};
    endfunction

    task automatic model_tick();
        logic [4:0] c;
        bit hold, writes;
        c = exp_ctrl();
        hold = hif.mem_req && !hif.mem_ack;
        writes = hif.id_valid && hif.id_reg_write && (hif.id_rd != 0);
        if (!rst_n) begin
            m_ex_rd = 0; m_ex_load = 0; m_mem_rd = 0; m_count = 0; m_wait = 0;
        end else begin
            if (c == 5'b11100) m_count = (m_count + 1 > 65535) ? 65535 : m_count + 1;
            if (m_wait) m_wait = !(hif.mem_ack || !hif.mem_req);
            else        m_wait = hold;
            if (!hold) begin
                m_mem_rd = m_ex_rd;
                if (c[2] || !writes) begin
                    m_ex_rd = 0; m_ex_load = 0;
                end else begin
                    m_ex_rd = int'(hif.id_rd);
                    m_ex_load = hif.id_is_load && hif.id_valid;
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic set_idle();
        rst_n = 1'b1;
        hif.id_valid = 0; hif.id_rs1 = 0; hif.id_rs2 = 0; hif.id_store_reg = 0;
        hif.id_use_rs1 = 0; hif.id_use_rs2 = 0; hif.id_use_store = 0;
        hif.id_rd = 0; hif.id_reg_write = 0; hif.id_is_load = 0;
        hif.ex_branch_taken = 0; hif.mem_req = 0; hif.mem_ack = 0;
    endtask

    task automatic drive_load_x5();
        set_idle();
        hif.id_valid = 1; hif.id_rd = 5; hif.id_reg_write = 1; hif.id_is_load = 1;
    endtask

    task automatic drive_use_rs2_x5(input bit use_it);
        set_idle();
        hif.id_valid = 1; hif.id_rs2 = 5; hif.id_use_rs2 = use_it;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        hif.mem_req = 1; hif.id_valid = 1; hif.id_rd = 7; hif.id_reg_write = 1;
        advance();
        advance();
        #1;
        checks++;
        if ({hif.ex_rd, hif.ex_is_load, hif.mem_rd} !== 11'd0) begin
            errors++; $display("FAIL reset_regs got ex_rd=%0d ex_is_load=%0b mem_rd=%0d want 0", hif.ex_rd, hif.ex_is_load, hif.mem_rd);
        end
        checks++;
        if (hif.mem_wait !== 1'b0 || hif.stall_count !== 16'd0) begin
            errors++; $display("FAIL reset_fsm got mem_wait=%0b count=%0d want 0/0", hif.mem_wait, hif.stall_count);
        end
        checks++;
        if (obs_ctrl() !== 5'b11001) begin
            errors++; $display("FAIL reset_comb got %b want 11001", obs_ctrl());
        end
        set_idle();
        advance();
    endtask

    task automatic test_load_use();
        drive_load_x5();
        #1;
        checks++;
        if (obs_ctrl() !== 5'b00000) begin
            errors++; $display("FAIL lu_setup got %b want 00000", obs_ctrl());
        end
        advance();
        drive_use_rs2_x5(1);
        #1;
        checks++;
        if (obs_ctrl() !== 5'b11100 || hif.ex_rd !== 5'd5 || hif.ex_is_load !== 1'b1) begin
            errors++; $display("FAIL lu_stall got ctrl=%b ex_rd=%0d ld=%0b want 11100/5/1", obs_ctrl(), hif.ex_rd, hif.ex_is_load);
        end
        advance();
        #1;
        checks++;
        if (obs_ctrl() !== 5'b00000 || hif.ex_rd !== 5'd0 || hif.mem_rd !== 5'd5 || hif.stall_count !== 16'd1) begin
            errors++; $display("FAIL lu_after got ctrl=%b ex_rd=%0d mem_rd=%0d cnt=%0d want 00000/0/5/1", obs_ctrl(), hif.ex_rd, hif.mem_rd, hif.stall_count);
        end
        advance();
    endtask

    task automatic test_no_stall();
        drive_load_x5();
        advance();
        drive_use_rs2_x5(0);
        #1;
        checks++;
        if (obs_ctrl() !== 5'b00000 || hif.stall_count !== 16'(m_count)) begin
            errors++; $display("FAIL no_stall_imm got ctrl=%b cnt=%0d want 00000/%0d", obs_ctrl(), hif.stall_count, m_count);
        end
        advance();
        set_idle();
        hif.id_valid = 1; hif.id_rd = 0; hif.id_reg_write = 1; hif.id_is_load = 1;
        advance();
        set_idle();
        hif.id_valid = 1; hif.id_rs1 = 0; hif.id_use_rs1 = 1; hif.id_rs2 = 0; hif.id_use_rs2 = 1;
        #1;
        checks++;
        if (obs_ctrl() !== 5'b00000 || hif.ex_rd !== 5'd0) begin
            errors++; $display("FAIL no_stall_x0 got ctrl=%b ex_rd=%0d want 00000/0", obs_ctrl(), hif.ex_rd);
        end
        advance();
        #1;
        checks++;
        if (hif.stall_count !== 16'd1) begin
            errors++; $display("FAIL no_stall_cnt got %0d want 1", hif.stall_count);
        end
    endtask

    task automatic test_flush();
        drive_load_x5();
        advance();
        drive_use_rs2_x5(1);
        hif.ex_branch_taken = 1;
        #1;
        checks++;
        if (obs_ctrl() !== 5'b00110) begin
            errors++; $display("FAIL flush_prio got %b want 00110", obs_ctrl());
        end
        advance();
        set_idle();
        #1;
        checks++;
        if (hif.stall_count !== 16'd1 || hif.ex_rd !== 5'd0) begin
            errors++; $display("FAIL flush_after got cnt=%0d ex_rd=%0d want 1/0", hif.stall_count, hif.ex_rd);
        end
        advance();
    endtask

    task automatic test_mem_wait();
        logic [4:0] ex0, mem0;
        set_idle();
        hif.id_valid = 1; hif.id_rd = 9; hif.id_reg_write = 1;
        advance();
        hif.id_rd = 12;
        advance();
        ex0 = hif.ex_rd; mem0 = hif.mem_rd;
        for (int i = 0; i < 3; i++) begin
            hif.mem_req = 1; hif.mem_ack = 0; hif.id_rd = 5'(20 + i);
            #1;
            checks++;
            if (obs_ctrl() !== 5'b11001 || hif.mem_wait !== (i > 0) || hif.ex_rd !== ex0 || hif.mem_rd !== mem0) begin
                errors++; $display("FAIL wait_hold[%0d] got ctrl=%b wait=%0b ex_rd=%0d mem_rd=%0d want 11001/%0b/%0d/%0d",
                                   i, obs_ctrl(), hif.mem_wait, hif.ex_rd, hif.mem_rd, i > 0, ex0, mem0);
            end
            advance();
        end
        hif.mem_ack = 1;
        #1;
        checks++;
        if (hif.freeze !== 1'b0 || hif.mem_wait !== 1'b1 || hif.ex_rd !== ex0) begin
            errors++; $display("FAIL wait_ack got freeze=%0b wait=%0b ex_rd=%0d want 0/1/%0d", hif.freeze, hif.mem_wait, hif.ex_rd, ex0);
        end
        advance();
        set_idle();
        hif.mem_req = 1; hif.mem_ack = 1;
        #1;
        checks++;
        if (hif.mem_wait !== 1'b0 || hif.freeze !== 1'b0) begin
            errors++; $display("FAIL same_cycle_ack got wait=%0b freeze=%0b want 0/0", hif.mem_wait, hif.freeze);
        end
        advance();
        #1;
        checks++;
        if (hif.mem_wait !== 1'b0) begin
            errors++; $display("FAIL same_cycle_run got wait=%0b want 0", hif.mem_wait);
        end
        hif.mem_ack = 0;
        advance();
        advance();
        hif.mem_req = 0;
        #1;
        checks++;
        if (hif.mem_wait !== 1'b1 || hif.freeze !== 1'b0) begin
            errors++; $display("FAIL abort_cycle got wait=%0b freeze=%0b want 1/0", hif.mem_wait, hif.freeze);
        end
        advance();
        #1;
        checks++;
        if (hif.mem_wait !== 1'b0) begin
            errors++; $display("FAIL abort_run got wait=%0b want 0", hif.mem_wait);
        end
    endtask

    task automatic test_reset_mid_wait();
        drive_load_x5();
        advance();
        set_idle();
        hif.mem_req = 1;
        advance();
        advance();
        rst_n = 1'b0;
        advance();
        rst_n = 1'b1; hif.mem_req = 0;
        #1;
        checks++;
        if (hif.mem_wait !== 1'b0 || hif.ex_rd !== 5'd0 || hif.mem_rd !== 5'd0 || hif.stall_count !== 16'd0) begin
            errors++; $display("FAIL reset_wait got wait=%0b ex_rd=%0d mem_rd=%0d cnt=%0d want 0/0/0/0",
                               hif.mem_wait, hif.ex_rd, hif.mem_rd, hif.stall_count);
        end
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            hif.id_valid = ($urandom_range(0, 3) != 0);
            hif.id_rs1 = 5'($urandom_range(0, 5));
            hif.id_rs2 = 5'($urandom_range(0, 5));
            hif.id_store_reg = 5'($urandom_range(0, 5));
            hif.id_use_rs1 = 1'($urandom);
            hif.id_use_rs2 = 1'($urandom);
            hif.id_use_store = ($urandom_range(0, 3) == 0);
            hif.id_rd = 5'($urandom_range(0, 5));
            hif.id_reg_write = ($urandom_range(0, 3) != 0);
            hif.id_is_load = ($urandom_range(0, 1) == 0);
            hif.ex_branch_taken = ($urandom_range(0, 7) == 0);
            hif.mem_req = ($urandom_range(0, 3) == 0) || (m_wait && $urandom_range(0, 3) != 0);
            hif.mem_ack = ($urandom_range(0, 2) == 0);
            #1;
            checks++;
            if (obs_ctrl() !== exp_ctrl()) begin
                errors++; $display("FAIL rand_ctrl[%0d] got %b want %b", n, obs_ctrl(), exp_ctrl());
            end
            checks++;
            if (int'(hif.ex_rd) != m_ex_rd || hif.ex_is_load !== m_ex_load || int'(hif.mem_rd) != m_mem_rd) begin
                errors++; $display("FAIL rand_rd[%0d] got ex=%0d/%0b mem=%0d want %0d/%0b/%0d",
                                   n, hif.ex_rd, hif.ex_is_load, hif.mem_rd, m_ex_rd, m_ex_load, m_mem_rd);
            end
            checks++;
            if (hif.mem_wait !== m_wait || int'(hif.stall_count) != m_count) begin
                errors++; $display("FAIL rand_state[%0d] got wait=%0b cnt=%0d want %0b/%0d", n, hif.mem_wait, hif.stall_count, m_wait, m_count);
            end
            advance();
        end
    endtask

    task automatic test_saturation();
        set_idle();
        #1;
        force dut.stall_count_q = 16'hFFFC;
        #1;
        release dut.stall_count_q;
        m_count = 16'hFFFC;
        for (int i = 0; i < 6; i++) begin
            drive_load_x5();
            advance();
            drive_use_rs2_x5(1);
            advance();
            #1;
            checks++;
            if (int'(hif.stall_count) != m_count) begin
                errors++; $display("FAIL sat_step[%0d] got %0h want %0h", i, hif.stall_count, m_count);
            end
        end
        checks++;
        if (hif.stall_count !== 16'hFFFF) begin
            errors++; $display("FAIL sat_final got %0h want ffff", hif.stall_count);
        end
    endtask

    initial begin
        m_ex_rd = 0; m_ex_load = 0; m_mem_rd = 0; m_count = 0; m_wait = 0;
        set_idle();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_no_stall();
        test_flush();
        test_mem_wait();
        test_reset_mid_wait();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
